// File: rtl/mac7879_s36.sv
// mac7879_s36: multiply-accumulate engine. It sums TERMS signed 13x13 products
// per run and hands a 36-bit signed total to the downstream mod-7879 reducer.
// Pipeline: accept beat -> product register -> accumulator. OutValid pulses
// in the same cycle that the final sum first appears on Out.
module mac7879_s36 #(
    parameter int TERMS = 761
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               InValid,
    input  logic signed [12:0] InA,
    input  logic signed [12:0] InB,
    output logic               InReady,
    output logic signed [35:0] Out,
    output logic               OutValid,
    output logic               Busy
);

    localparam int CW = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(TERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic                 first_term;
    logic signed [25:0]   product;
    logic                 prod_valid;
    logic                 prod_last;
    logic signed [35:0]   acc;
    logic                 accept;

    assign accept = InValid && InReady;
    assign Out    = acc;

    // Run sequencing: IDLE waits for Start, RUN counts accepted beats, DRAIN lets the last product land.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            count   <= '0;
            InReady <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= RUN;
                        count   <= '0;
                        InReady <= 1'b1;
                        Busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        count <= count + CW'(1);
                        if (count == LAST_BEAT) begin
                            state   <= DRAIN;
                            InReady <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    InReady <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

    // Product stage: capture the full-width product of each accepted beat and tag the final one.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            product    <= '0;
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else begin
            prod_valid <= accept;
            prod_last  <= accept && (count == LAST_BEAT);
            if (accept) begin
                product <= 26'(InA) * 26'(InB);
            end
        end
    end

    // Accumulate stage: the first product of a run replaces the old total, later ones add to it.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            acc        <= '0;
            first_term <= 1'b0;
            OutValid   <= 1'b0;
        end else begin
            OutValid <= prod_valid && prod_last;
            if (prod_valid) begin
                if (first_term) begin
                    acc        <= 36'(product);
                    first_term <= 1'b0;
                end else begin
                    acc <= acc + 36'(product);
                end
            end
            if (state == IDLE && Start) begin
                first_term <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac7879_s36.sv
// tb_mac7879_s36: directed and randomized runs on a TERMS=4 instance and a
// TERMS=2048 instance, each run compared with a sum-of-products reference.
module tb_mac7879_s36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic Reset;

    logic               start_s, valid_s, ready_s, ov_s, busy_s;
    logic signed [12:0] a_s, b_s;
    logic signed [35:0] out_s;

    logic               start_b, valid_b, ready_b, ov_b, busy_b;
    logic signed [12:0] a_b, b_b;
    logic signed [35:0] out_b;

    int     vectors    = 0;
    int     miscompares = 0;
    int     ra[4];
    int     rb[4];
    longint last_out_s = 0;
    bit     pre;
    bit     chain;

    mac7879_s36 #(.TERMS(4)) dut_small (
        .clk(clk), .Reset(Reset), .Start(start_s), .InValid(valid_s),
        .InA(a_s), .InB(b_s), .InReady(ready_s), .Out(out_s),
        .OutValid(ov_s), .Busy(busy_s)
    );

    mac7879_s36 #(.TERMS(2048)) dut_big (
        .clk(clk), .Reset(Reset), .Start(start_b), .InValid(valid_b),
        .InA(a_b), .InB(b_b), .InReady(ready_b), .Out(out_b),
        .OutValid(ov_b), .Busy(busy_b)
    );

    function automatic logic signed [12:0] rnd13();
        int v;
        v = int'($urandom_range(7878, 0)) - 3939;
        return 13'(v);
    endfunction

    function automatic longint model4();
        longint s = 0;
        for (int i = 0; i < 4; i++) s += longint'(ra[i]) * longint'(rb[i]);
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [35:0] obs,
                               input logic signed [35:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One TERMS=4 run using ra/rb; entered and left just after a falling edge.
    task automatic applyStimulus(input int gap_max, input bit midstart,
                                 input bit prestarted, input bit chain_next);
        longint exp;
        exp = model4();
        if (!prestarted) begin
            start_s = 1'b1; valid_s = 1'b1; a_s = rnd13(); b_s = rnd13();
            @(negedge clk);
            start_s = 1'b0;
        end
        checkOutput("run_ready", 36'(ready_s), 36'(1));
        checkOutput("run_busy", 36'(busy_s), 36'(1));
        checkOutput("out_hold_prev", out_s, 36'(last_out_s));
        for (int i = 0; i < 4; i++) begin
            repeat (int'($urandom_range(gap_max, 0))) begin
                valid_s = 1'b0; a_s = rnd13(); b_s = rnd13(); start_s = midstart;
                @(negedge clk);
            end
            valid_s = 1'b1; a_s = 13'(ra[i]); b_s = 13'(rb[i]); start_s = midstart;
            @(negedge clk);
        end
        start_s = 1'b0; valid_s = 1'b1; a_s = rnd13(); b_s = rnd13();
        checkOutput("drain_ready", 36'(ready_s), 36'(0));
        checkOutput("drain_busy", 36'(busy_s), 36'(1));
        checkOutput("drain_outvalid", 36'(ov_s), 36'(0));
        @(negedge clk);
        checkOutput("final_outvalid", 36'(ov_s), 36'(1));
        checkOutput("final_out", out_s, 36'(exp));
        checkOutput("final_busy", 36'(busy_s), 36'(0));
        last_out_s = exp;
        if (chain_next) begin
            start_s = 1'b1;
            @(negedge clk);
            start_s = 1'b0; valid_s = 1'b0;
        end else begin
            @(negedge clk);
            valid_s = 1'b0;
            checkOutput("outvalid_pulse_end", 36'(ov_s), 36'(0));
            checkOutput("out_held", out_s, 36'(exp));
        end
    endtask

    // One TERMS=2048 run; mode 0: 3939*3939, 1: -3939*3939, 2: random in range.
    task automatic bigRun(input int mode);
        longint exp = 0;
        int a, b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        checkOutput("big_ready", 36'(ready_b), 36'(1));
        for (int i = 0; i < 2048; i++) begin
            a = (mode == 1) ? -3939 : 3939;
            b = 3939;
            if (mode == 2) begin
                a = int'(rnd13());
                b = int'(rnd13());
            end
            exp += longint'(a) * longint'(b);
            valid_b = 1'b1; a_b = 13'(a); b_b = 13'(b);
            @(negedge clk);
        end
        valid_b = 1'b1;
        checkOutput("big_drain_ready", 36'(ready_b), 36'(0));
        @(negedge clk);
        valid_b = 1'b0;
        checkOutput("big_outvalid", 36'(ov_b), 36'(1));
        checkOutput("big_out", out_b, 36'(exp));
        @(negedge clk);
        checkOutput("big_outvalid_end", 36'(ov_b), 36'(0));
    endtask

    initial begin
        Reset = 1'b1;
        start_s = 1'b0; valid_s = 1'b0; a_s = '0; b_s = '0;
        start_b = 1'b0; valid_b = 1'b0; a_b = '0; b_b = '0;
        #2;
        checkOutput("rst_out", out_s, 36'(0));
        checkOutput("rst_ready", 36'(ready_s), 36'(0));
        checkOutput("rst_outvalid", 36'(ov_s), 36'(0));
        checkOutput("rst_busy", 36'(busy_s), 36'(0));
        checkOutput("rst_big_out", out_b, 36'(0));
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
        valid_s = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_ready", 36'(ready_s), 36'(0));
        checkOutput("idle_busy", 36'(busy_s), 36'(0));
        valid_s = 1'b0;

        // basic run
        ra = '{1, 2, 3, 4}; rb = '{5, 6, 7, 8};
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_70", out_s, 36'(70));

        // extreme negative products
        ra = '{-3939, -3939, -3939, -3939}; rb = '{3939, 3939, 3939, 3939};
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        checkOutput("neg_extreme", out_s, 36'(-62062884));

        // bubbles between beats
        ra = '{1, 2, 3, 4}; rb = '{5, 6, 7, 8};
        applyStimulus(3, 1'b0, 1'b0, 1'b0);
        checkOutput("bubbles_70", out_s, 36'(70));

        // Start ignored mid-run, then back-to-back run started in the OutValid cycle
        applyStimulus(1, 1'b1, 1'b0, 1'b1);
        ra = '{1, 1, 1, 1}; rb = '{-1, -1, -1, -1};
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        checkOutput("chained_minus4", out_s, 36'(-4));

        // randomized runs, some chained
        pre = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++) begin
                ra[i] = int'(rnd13());
                rb[i] = int'(rnd13());
            end
            chain = (k < 9) ? 1'($urandom_range(1, 0)) : 1'b0;
            applyStimulus(3, 1'b0, pre, chain);
            pre = chain;
        end

        // reset aborts a run after two beats
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid_s = 1'b1; a_s = 13'(3000); b_s = 13'(3000);
            @(negedge clk);
        end
        Reset = 1'b1;
        #1;
        checkOutput("abort_out", out_s, 36'(0));
        checkOutput("abort_ready", 36'(ready_s), 36'(0));
        checkOutput("abort_busy", 36'(busy_s), 36'(0));
        checkOutput("abort_outvalid", 36'(ov_s), 36'(0));
        @(negedge clk);
        Reset = 1'b0;
        last_out_s = 0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("after_abort_outvalid", 36'(ov_s), 36'(0));
            checkOutput("after_abort_busy", 36'(busy_s), 36'(0));
        end
        valid_s = 1'b0;
        ra = '{1, 2, 3, 4}; rb = '{5, 6, 7, 8};
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_abort_70", out_s, 36'(70));

        // long runs without wrap
        bigRun(0);
        checkOutput("big_pos_const", out_b, 36'sd31776196608);
        bigRun(1);
        checkOutput("big_neg_const", out_b, -36'sd31776196608);
        bigRun(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
